refresh_scheduler: RTL

Refresh scheduler for the DRAM controller. It times the refresh interval, tracks how many refreshes are owed, and decides each cycle whether the host command path or a REFRESH owns the DRAM command bus. Refreshes are postponed while the host is active, up to a bounded debt. It sits between the refresh interval timer function and the command sequencer, gating host traffic through `host_grant`.

---
 rtl/refresh_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/refresh_scheduler.sv
// DRAM refresh scheduler: interval timer, refresh debt, and host/REFRESH arbitration.
// ref_cmd two cycles after debt appears with host quiet and mem_idle; host_grant held low while a refresh is owed and due.
module refresh_scheduler #(
    parameter int TREFI    = 1170,
    parameter int TRFC     = 53,
    parameter int MAX_PEND = 8,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          host_req,
    input  logic                          mem_idle,
    output logic                          host_grant,
    output logic                          ref_cmd,
    output logic                          ref_busy,
    output logic                          urgent,
    output logic [$clog2(MAX_PEND+1)-1:0] pending,
    output logic                          overflow
);

    localparam int PW = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, REF} state_t;

    state_t           state;
    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] trfc;
    logic             tick;
    logic             want_ref;

    assign tick       = en && (icnt == CNT_W'(TREFI - 1));
    assign urgent     = (pending == PW'(MAX_PEND));
    // Debt is serviced when the host is quiet, or unconditionally once it is at its ceiling.
    assign want_ref   = (pending != '0) && (urgent || !host_req);
    assign host_grant = (state == IDLE) && !want_ref && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            icnt     <= '0;
            trfc     <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            ref_cmd  <= 1'b0;
            ref_busy <= 1'b0;
        end else begin
            if (en) begin
                icnt <= tick ? '0 : icnt + CNT_W'(1);
            end

            // A tick that coincides with ref_cmd cancels out, so it can never overflow.
            case ({tick, ref_cmd})
                2'b10: begin
                    if (pending == PW'(MAX_PEND)) begin
                        overflow <= 1'b1;
                    end else begin
                        pending <= pending + PW'(1);
                    end
                end
                2'b01:   pending <= pending - PW'(1);
                default: ;
            endcase

            ref_cmd <= 1'b0;
            case (state)
                IDLE: begin
                    if (want_ref) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_idle) begin
                        state    <= REF;
                        ref_cmd  <= 1'b1;
                        ref_busy <= 1'b1;
                        trfc     <= CNT_W'(TRFC - 1);
                    end
                end
                REF: begin
                    if (trfc == '0) begin
                        state    <= IDLE;
                        ref_busy <= 1'b0;
                    end else begin
                        trfc <= trfc - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
